// File: rtl/cpu_sequencer_pkg.sv
// Shared state encoding and instruction constants for the CPU sequencer.
// Imported by the top-level sequencer and by its next-PC sub-module.
package cpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_DMEM  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;
    localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/cpu_sequencer_next_pc.sv
// Next-PC selection for the sequencer: sequential, PC-relative or register target,
// plus a flag that marks a target that is not word aligned.
module cpu_sequencer_next_pc
    import cpu_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm32,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    input  logic        direct_branch,
    output logic [31:0] target,
    output logic        misaligned
);

    // Register targets drop bit 0 before the alignment check, as JALR requires.
    always_comb begin
        if (branch_taken && direct_branch) begin
            target = pc + imm32;
        end else if (branch_taken) begin
            target = {alu_result[31:1], 1'b0};
        end else begin
            target = pc + PC_STEP;
        end
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, optional store handshake,
// with EBREAK halt and a terminal error state for ack timeouts or bad targets.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        rf_we_in,
    input  logic        mem_we_in,
    input  logic        branch_taken,
    input  logic        direct_branch,
    input  logic [31:0] imm32,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic [31:0] retired,
    output logic        halted,
    output logic        err
);

    localparam int               CNT_W     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_ZERO = CNT_W'(0);

    state_t           state_r, state_s;
    logic [31:0]      pc_r, pc_s, ir_r, ir_s, retired_r, retired_s;
    logic [CNT_W-1:0] wait_r, wait_s;
    logic             imem_req_r, dmem_req_r, halted_r, err_r, rf_we_s;
    logic [31:0]      npc_s;
    logic             npc_misaligned_s;

    cpu_sequencer_next_pc u_next_pc (
        .pc            (pc_r),
        .imm32         (imm32),
        .alu_result    (alu_result),
        .branch_taken  (branch_taken),
        .direct_branch (direct_branch),
        .target        (npc_s),
        .misaligned    (npc_misaligned_s)
    );

    // Next-state, architectural updates and the single-cycle register-write gate.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        retired_s = retired_r;
        wait_s    = wait_r;
        rf_we_s   = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_s    = imem_rdata;
                    state_s = ST_EXEC;
                end else if (wait_r == WAIT_LAST) begin
                    state_s = ST_ERR;
                end else begin
                    wait_s = wait_r + WAIT_ONE;
                end
            end
            ST_EXEC: begin
                wait_s = WAIT_ZERO;
                if (ir_r == EBREAK_INSN) begin
                    state_s = ST_HALT;
                end else if (mem_we_in) begin
                    state_s = ST_DMEM;
                end else if (npc_misaligned_s) begin
                    state_s = ST_ERR;
                end else begin
                    rf_we_s   = rf_we_in;
                    pc_s      = npc_s;
                    retired_s = retired_r + 32'd1;
                    state_s   = ST_FETCH;
                end
            end
            ST_DMEM: begin
                if (dmem_ack) begin
                    pc_s      = pc_r + PC_STEP;
                    retired_s = retired_r + 32'd1;
                    wait_s    = WAIT_ZERO;
                    state_s   = ST_FETCH;
                end else if (wait_r == WAIT_LAST) begin
                    state_s = ST_ERR;
                end else begin
                    wait_s = wait_r + WAIT_ONE;
                end
            end
            ST_HALT: state_s = ST_HALT;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_ERR;
        endcase
    end

    // State and datapath registers; request/status flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            ir_r       <= 32'd0;
            retired_r  <= 32'd0;
            wait_r     <= WAIT_ZERO;
            imem_req_r <= 1'b1;
            dmem_req_r <= 1'b0;
            halted_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            retired_r  <= retired_s;
            wait_r     <= wait_s;
            imem_req_r <= (state_s == ST_FETCH);
            dmem_req_r <= (state_s == ST_DMEM);
            halted_r   <= (state_s == ST_HALT);
            err_r      <= (state_s == ST_ERR);
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign ir        = ir_r;
    assign pc        = pc_r;
    assign pc_plus4  = pc_r + PC_STEP;
    assign rf_we     = rf_we_s;
    assign dmem_req  = dmem_req_r;
    assign retired   = retired_r;
    assign halted    = halted_r;
    assign err       = err_r;

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15, max wait cycles for imem_ack/dmem_ack.
REQ-003 SHALL use one clock and an asynchronous active-low reset:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  imem_req  out  1  instruction fetch request
  imem_addr  out  32  fetch address (= pc)
  imem_ack  in  1  fetch complete, imem_rdata valid
  imem_rdata  in  32  fetched instruction
  ir  out  32  instruction register, feeds decoder instr
  pc  out  32  current PC
  pc_plus4  out  32  pc+4, link value for JAL/JALR
  rf_we_in  in  1  decoder register-write enable
  mem_we_in  in  1  decoder store enable
  branch_taken  in  1  decoder branch decision
  direct_branch  in  1  1: pc+imm32, 0: register target
  imm32  in  32  decoder immediate
  alu_result  in  32  ALU output
  rf_we  out  1  gated register-file write enable
  dmem_req  out  1  store request
  dmem_ack  in  1  store complete
  retired  out  32  retired-instruction count
  halted  out  1  EBREAK reached
  err  out  1  timeout or misaligned target

Function
REQ-004 SHALL implement states FETCH, EXEC, DMEM, HALT, ERR; state after reset is FETCH.
REQ-005 FETCH: imem_req=1, imem_addr=pc; on imem_ack capture ir<=imem_rdata, go EXEC next cycle; imem_req low in EXEC.
REQ-006 EXEC lasts exactly one cycle; ir SHALL be stable throughout EXEC and DMEM.
REQ-007 EXEC with ir==32'h0010_0073 (EBREAK): go HALT; no PC update, no retire, rf_we=0.
REQ-008 EXEC with mem_we_in=1: go DMEM; rf_we=0.
REQ-009 EXEC otherwise: rf_we=rf_we_in for that cycle only; update pc; retired+=1; go FETCH.
REQ-010 DMEM: dmem_req=1 until dmem_ack; on ack pc<=pc+4, retired+=1, go FETCH.
REQ-011 Next PC: branch_taken&direct_branch -> pc+imm32; branch_taken&!direct_branch -> alu_result with bit0 cleared; else pc+4; all mod 2^32.
REQ-012 Next PC with bits[1:0]!=0: go ERR, pc unchanged, no retire, rf_we=0.
REQ-013 Wait counter resets on entry to FETCH/DMEM, increments each cycle without ack; at ACK_TIMEOUT cycles without ack go ERR.
REQ-014 Ack arriving in the same cycle the counter reaches ACK_TIMEOUT SHALL win: transaction completes normally.
REQ-015 imem_ack outside FETCH and dmem_ack outside DMEM SHALL be ignored.
REQ-016 HALT: halted=1; ERR: err=1; both terminal until reset, all requests and rf_we low.
REQ-017 rf_we SHALL be 0 in every state except EXEC.
REQ-018 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-019 pc_plus4 SHALL be combinational pc+4.

Reset
REQ-020 rst_n low SHALL immediately force state=FETCH, pc=RESET_PC, ir=0, retired=0, wait counter=0, rf_we=0, dmem_req=0, halted=0, err=0.
REQ-021 Reset asserted mid-FETCH or mid-DMEM SHALL abandon the transaction; no retire, no write.
REQ-022 imem_req SHALL assert in the first clk cycle after rst_n deasserts.

Structure
REQ-023 State encodings and the EBREAK constant SHALL live in a shared header alongside alu.mac.vh.
REQ-024 The next-PC selection plus misalignment check SHALL be one sub-module, next_pc.

Verification
REQ-025 ADDI at 0x0, imem_ack after 2 cycles -> ir loaded, one-cycle rf_we pulse, pc=0x4, retired=1.
REQ-026 SW at 0x8, dmem_ack after 3 cycles -> dmem_req high 3 cycles, rf_we never high, pc=0xC, retired+1.
REQ-027 BEQ at 0x10, branch_taken=1, direct_branch=1, imm32=-8 -> pc=0x8; JALR with alu_result=0x21 -> pc=0x20.
REQ-028 JALR with alu_result=0x22 -> err=1, pc unchanged, retired unchanged.
REQ-029 imem_ack withheld 15 cycles -> err=1, imem_req low; ack on exactly the 15th cycle -> normal EXEC.
REQ-030 EBREAK fetched -> halted=1 next cycle; rst_n pulsed mid-DMEM -> pc=RESET_PC, dmem_req=0 immediately.
